// File: rtl/lut_pkg.sv
// Shared types and geometry for the data-memory address LUT and its encoder.
package lut_pkg;

  // Default LUT geometry: 8-bit addresses, 4 banks of 8 entries
  localparam int LUT_D     = 8;
  localparam int LUT_NB    = 4;
  localparam int LUT_IW    = 3;
  localparam int BANK_SIZE = 2 ** LUT_IW;
  localparam int MAX_ADDR  = LUT_NB * BANK_SIZE - 1;

  // Field kinds emitted toward the instruction emitter
  typedef enum logic [1:0] {
    K_INA = 2'd0,
    K_LW  = 2'd1,
    K_SW  = 2'd2,
    K_ERR = 2'd3
  } kind_t;

  // Encoder sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    ISSUE = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/lut_addr_encoder.sv
// Converts a data-memory address request into the LUT field stream:
// zero or more INA bank steps followed by one LW/SW carrying the bank index.
// The LUT's incAddr is mirrored in cur_bank so only the needed INAs are sent.
module lut_addr_encoder
  import lut_pkg::*;
#(
  parameter int D  = LUT_D,
  parameter int NB = LUT_NB,
  parameter int IW = LUT_IW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [D-1:0]  req_addr,
  input  logic          req_is_store,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_kind,
  output logic [IW-1:0] out_field,
  output logic [1:0]    cur_bank,
  output logic          busy
);

  // First address past the last LUT entry; anything at or above is unreachable
  localparam logic [D:0] ADDR_LIMIT = (D+1)'(NB * (2 ** IW));

  state_t        state_q;
  logic [1:0]    cur_bank_q;
  logic [1:0]    tgt_bank_q;
  logic [IW-1:0] idx_q;
  logic          store_q;
  logic          out_valid_q;
  kind_t         out_kind_q;
  logic [IW-1:0] out_field_q;

  logic [1:0]    req_bank;
  logic [IW-1:0] req_idx;
  logic          req_oor;
  logic [1:0]    bank_inc;

  // Address decode of the incoming request and the mod-NB bank successor
  always_comb begin
    req_idx  = req_addr[IW-1:0];
    req_bank = req_addr[IW+1:IW];
    req_oor  = ({1'b0, req_addr} >= ADDR_LIMIT);
    bank_inc = (cur_bank_q == 2'(NB - 1)) ? 2'd0 : cur_bank_q + 2'd1;
  end

  // Sequencer: latch request, walk banks with INA, then issue LW/SW or ERR
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cur_bank_q  <= 2'd0;
      out_valid_q <= 1'b0;
      out_kind_q  <= K_INA;
      out_field_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            idx_q       <= req_idx;
            tgt_bank_q  <= req_bank;
            store_q     <= req_is_store;
            out_valid_q <= 1'b1;
            if (req_oor) begin
              state_q     <= ERR;
              out_kind_q  <= K_ERR;
              out_field_q <= '0;
            end else if (req_bank == cur_bank_q) begin
              state_q     <= ISSUE;
              out_kind_q  <= req_is_store ? K_SW : K_LW;
              out_field_q <= req_idx;
            end else begin
              state_q     <= STEP;
              out_kind_q  <= K_INA;
              out_field_q <= '0;
            end
          end
        end
        STEP: begin
          // Each accepted INA advances the mirrored LUT bank by one
          if (out_ready) begin
            cur_bank_q <= bank_inc;
            if (bank_inc == tgt_bank_q) begin
              state_q     <= ISSUE;
              out_kind_q  <= store_q ? K_SW : K_LW;
              out_field_q <= idx_q;
            end
          end
        end
        ISSUE, ERR: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_kind_q  <= K_INA;
            out_field_q <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Request acceptance only in IDLE and never while reset is held
  always_comb begin
    req_ready = (state_q == IDLE) && Reset;
    busy      = (state_q != IDLE);
    out_valid = out_valid_q;
    out_kind  = out_kind_q;
    out_field = out_field_q;
    cur_bank  = cur_bank_q;
  end

endmodule

// File: tb/tb_lut_addr_encoder.sv
// Randomised and directed bench for lut_addr_encoder against a queue-based
// model of the expected field stream for each request.
module tb_lut_addr_encoder;

  logic       Clk;
  logic       Reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic       req_is_store;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_kind;
  logic [2:0] out_field;
  logic [1:0] cur_bank;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: tracked bank and expected stream for the current request
  int model_bank = 0;
  int exp_kind[$];
  int exp_field[$];
  int exp_bank[$];

  lut_addr_encoder #(.D(8), .NB(4), .IW(3)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_is_store(req_is_store),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_kind    (out_kind),
    .out_field   (out_field),
    .cur_bank    (cur_bank),
    .busy        (busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected stream: (tgt - cur) mod 4 INAs, then LW/SW, or a lone ERR
  task automatic model_request(input int a, input bit st);
    int tgt;
    int n;
    exp_kind.delete();
    exp_field.delete();
    exp_bank.delete();
    if (a >= 32) begin
      exp_kind.push_back(3);
      exp_field.push_back(0);
      exp_bank.push_back(model_bank);
    end else begin
      tgt = a / 8;
      n = (tgt - model_bank + 4) % 4;
      for (int k = 0; k < n; k++) begin
        exp_kind.push_back(0);
        exp_field.push_back(0);
        exp_bank.push_back((model_bank + k) % 4);
      end
      exp_kind.push_back(st ? 2 : 1);
      exp_field.push_back(a % 8);
      exp_bank.push_back(tgt);
      model_bank = tgt;
    end
  endtask

  function automatic bit ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (c < 2) ? 1'b0 : (c % 2 == 0);
    return 1'b1 & $urandom_range(0, 1);
  endfunction

  // Present a request at a negedge, then consume and check its whole stream
  task automatic send_req(input int a, input bit st, input int mode);
    int idx;
    int c;
    bit rdy;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge Clk);
    check("req_ready_idle", int'(req_ready), 1);
    model_request(a, st);
    req_addr     = 8'(a);
    req_is_store = st;
    req_valid    = 1'b1;
    out_ready    = 1'b0;
    @(negedge Clk);
    req_valid = 1'b0;
    idx = 0;
    c   = 0;
    while (idx < exp_kind.size() && c < 200) begin
      check("out_valid", int'(out_valid), 1);
      check("out_kind", int'(out_kind), exp_kind[idx]);
      check("out_field", int'(out_field), exp_field[idx]);
      check("cur_bank", int'(cur_bank), exp_bank[idx]);
      check("req_ready_busy", int'(req_ready), 0);
      rdy = ready_for(mode, c);
      out_ready = rdy;
      @(negedge Clk);
      if (rdy) idx++;
      c++;
    end
    if (idx < exp_kind.size()) check("handshake_budget", idx, exp_kind.size());
    out_ready = 1'b0;
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_req_ready", int'(req_ready), 1);
    check("idle_cur_bank", int'(cur_bank), model_bank);
  endtask

  initial begin
    Reset        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 8'd0;
    req_is_store = 1'b0;
    out_ready    = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_kind", int'(out_kind), 0);
    check("rst_out_field", int'(out_field), 0);
    check("rst_cur_bank", int'(cur_bank), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_req_ready", int'(req_ready), 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Directed walk: same bank, forward steps, wrap, out-of-range
    send_req(5, 1'b0, 0);
    send_req(21, 1'b1, 0);
    send_req(10, 1'b0, 0);
    send_req(40, 1'b0, 0);

    // Reset during STEP after the first INA handshake (bank 1 -> target 0)
    check("pre_mid_bank", int'(cur_bank), 1);
    req_addr     = 8'd5;
    req_is_store = 1'b0;
    req_valid    = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    check("mid_first_kind", int'(out_kind), 0);
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
    check("mid_bank_after_ina", int'(cur_bank), 2);
    check("mid_still_busy", int'(busy), 1);
    Reset = 1'b0;
    @(negedge Clk);
    check("mid_rst_cur_bank", int'(cur_bank), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_req_ready", int'(req_ready), 0);
    Reset = 1'b1;
    model_bank = 0;
    @(negedge Clk);
    check("mid_rel_req_ready", int'(req_ready), 1);
    check("mid_rel_out_valid", int'(out_valid), 0);

    // Backpressure pattern 0,0,1,0,1,... from bank 0 to address 30
    send_req(30, 1'b0, 2);

    // Randomised requests with random backpressure
    for (int i = 0; i < 40; i++) begin
      int a;
      if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 255);
      else a = $urandom_range(0, 31);
      send_req(a, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
